// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite/background palette-index RAM loader
// and the colour mapper address math.
package sprite_pkg;

    localparam int unsigned BIRD_CAP    = 1600;     // 40x40
    localparam int unsigned PIPE_CAP    = 38400;    // 80x480
    localparam int unsigned BACK_CAP    = 307200;   // 640x480
    localparam int unsigned TIMEOUT_DEF = 1000000;

    localparam int ADDR_W = 19;
    localparam int LEN_W  = 16;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] TGT_BIRD = 2'd0;
    localparam logic [1:0] TGT_PIPE = 2'd1;
    localparam logic [1:0] TGT_BACK = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_TGT   = 4'd1,
        ST_LLO   = 4'd2,
        ST_LHI   = 4'd3,
        ST_OFS   = 4'd4,
        ST_FETCH = 4'd5,
        ST_WLO   = 4'd6,
        ST_WHI   = 4'd7,
        ST_CHK   = 4'd8
    } loader_state_t;

    // Write-select bit for a target code; codes above TGT_BACK map to no RAM.
    function automatic logic [2:0] tgt_onehot(input logic [1:0] tgt);
        return 3'b001 << tgt;
    endfunction

endpackage

// File: rtl/stream_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and pulses
// expire on the LIMIT-th one.
module stream_timeout #(
    parameter int unsigned LIMIT = 1000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    assign expire = enable && !clear && (count == LAST);

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_ram_writer.sv
// Host-side loader: parses framed byte stream, unpacks two 4-bit palette
// indices per byte and drives a registered write port per sprite RAM.
module sprite_ram_writer
    import sprite_pkg::*;
#(
    parameter int unsigned BIRD_PIX = BIRD_CAP,
    parameter int unsigned PIPE_PIX = PIPE_CAP,
    parameter int unsigned BACK_PIX = BACK_CAP,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [2:0]          wr_sel,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [3:0]          wr_data,
    output logic                busy,
    output logic                done,
    output logic [3:0]          err,
    output loader_state_t       state_dbg
);

    localparam logic [19:0] BIRD_LIM = 20'(BIRD_PIX);
    localparam logic [19:0] PIPE_LIM = 20'(PIPE_PIX);
    localparam logic [19:0] BACK_LIM = 20'(BACK_PIX);

    loader_state_t state, state_nxt;

    logic                accept;
    logic                tmo_clear, tmo_enable, tmo_expire;
    logic [1:0]          tgt_q;
    logic [7:0]          len_lo_q;
    logic [LEN_W-1:0]    len_q, len_now;
    logic [3:0]          hi_q;
    logic [7:0]          chk_q;
    logic [ADDR_W-1:0]   addr_q, rem_q;
    logic [19:0]         tgt_cap;
    logic                len_over;
    logic [24:0]         back_total;
    logic                back_over;

    logic [2:0]          wr_sel_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [3:0]          wr_data_d;
    logic                done_d;
    logic [3:0]          err_d;

    // Handshake: a byte transfers on any edge where in_valid && in_ready;
    // in_ready depends only on state and Reset, never on in_valid.
    assign accept = in_valid && in_ready;

    assign len_now    = {in_data, len_lo_q};
    assign len_over   = {4'd0, len_now} > tgt_cap;
    // Background chunks start at offset*65536; the whole chunk must fit.
    assign back_total = {1'b0, in_data, 16'h0000} + {9'd0, len_q};
    assign back_over  = back_total > 25'(BACK_PIX);

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    always_comb begin
        case (tgt_q)
            TGT_BIRD: tgt_cap = BIRD_LIM;
            TGT_PIPE: tgt_cap = PIPE_LIM;
            default:  tgt_cap = BACK_LIM;
        endcase
    end

    // Watchdog runs only while waiting on the host mid-frame.
    assign tmo_clear  = accept || (state == ST_IDLE);
    assign tmo_enable = state inside {ST_TGT, ST_LLO, ST_LHI, ST_OFS, ST_FETCH, ST_CHK};

    stream_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expire (tmo_expire)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && in_data == SYNC_BYTE) state_nxt = ST_TGT;
            end
            ST_TGT: begin
                if (tmo_expire)  state_nxt = ST_IDLE;
                else if (accept) state_nxt = (in_data > 8'd2) ? ST_IDLE : ST_LLO;
            end
            ST_LLO: begin
                if (tmo_expire)  state_nxt = ST_IDLE;
                else if (accept) state_nxt = ST_LHI;
            end
            ST_LHI: begin
                if (tmo_expire) begin
                    state_nxt = ST_IDLE;
                end else if (accept) begin
                    if (tgt_q == TGT_BACK)  state_nxt = ST_OFS;
                    else if (len_over)      state_nxt = ST_IDLE;
                    else if (len_now == '0) state_nxt = ST_CHK;
                    else                    state_nxt = ST_FETCH;
                end
            end
            ST_OFS: begin
                if (tmo_expire) begin
                    state_nxt = ST_IDLE;
                end else if (accept) begin
                    if (back_over)        state_nxt = ST_IDLE;
                    else if (len_q == '0) state_nxt = ST_CHK;
                    else                  state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (tmo_expire)  state_nxt = ST_IDLE;
                else if (accept) state_nxt = ST_WLO;
            end
            ST_WLO:  state_nxt = (rem_q == 19'd1) ? ST_CHK : ST_WHI;
            ST_WHI:  state_nxt = (rem_q == 19'd1) ? ST_CHK : ST_FETCH;
            ST_CHK: begin
                if (tmo_expire || accept) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: in_ready plus next values of the registered write port and pulses
    always_comb begin
        in_ready  = 1'b0;
        wr_sel_d  = 3'b000;
        wr_addr_d = addr_q;
        wr_data_d = 4'h0;
        done_d    = 1'b0;
        err_d     = 4'b0000;
        case (state)
            ST_IDLE, ST_TGT, ST_LLO, ST_LHI, ST_OFS, ST_FETCH, ST_CHK: in_ready = !Reset;
            default: in_ready = 1'b0;
        endcase
        case (state)
            ST_TGT: begin
                if (accept && in_data > 8'd2) err_d[0] = 1'b1;
            end
            ST_LHI: begin
                if (accept && tgt_q != TGT_BACK && len_over) err_d[1] = 1'b1;
            end
            ST_OFS: begin
                if (accept && back_over) err_d[1] = 1'b1;
            end
            ST_FETCH: begin
                if (accept) begin
                    wr_sel_d  = tgt_onehot(tgt_q);
                    wr_addr_d = addr_q;
                    wr_data_d = in_data[3:0];
                end
            end
            ST_WLO: begin
                // An odd-length tail stops here; its high nibble is never written.
                if (rem_q != 19'd1) begin
                    wr_sel_d  = tgt_onehot(tgt_q);
                    wr_addr_d = addr_q + 19'd1;
                    wr_data_d = hi_q;
                end
            end
            ST_CHK: begin
                if (accept) begin
                    if (in_data == chk_q) done_d   = 1'b1;
                    else                  err_d[2] = 1'b1;
                end
            end
            default: ;
        endcase
        if (tmo_expire) err_d[3] = 1'b1;
    end

    // Datapath and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tgt_q    <= 2'd0;
            len_lo_q <= 8'd0;
            len_q    <= '0;
            hi_q     <= 4'h0;
            chk_q    <= 8'd0;
            addr_q   <= '0;
            rem_q    <= '0;
            wr_sel   <= 3'b000;
            wr_addr  <= '0;
            wr_data  <= 4'h0;
            done     <= 1'b0;
            err      <= 4'b0000;
        end else begin
            wr_sel  <= wr_sel_d;
            wr_addr <= wr_addr_d;
            wr_data <= wr_data_d;
            done    <= done_d;
            err     <= err_d;
            case (state)
                ST_TGT: if (accept) tgt_q <= in_data[1:0];
                ST_LLO: if (accept) len_lo_q <= in_data;
                ST_LHI: begin
                    if (accept) begin
                        len_q  <= len_now;
                        rem_q  <= 19'(len_now);
                        addr_q <= '0;
                        chk_q  <= 8'd0;
                    end
                end
                ST_OFS:   if (accept) addr_q <= {in_data[2:0], 16'h0000};
                ST_FETCH: begin
                    if (accept) begin
                        hi_q  <= in_data[7:4];
                        chk_q <= chk_q ^ in_data;
                    end
                end
                ST_WLO, ST_WHI: begin
                    addr_q <= addr_q + 19'd1;
                    rem_q  <= rem_q - 19'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Self-checking bench for sprite_ram_writer: frame-level reference model,
// randomized payloads, header errors, timeout, reset and backpressure.
module tb_sprite_ram_writer;
    import sprite_pkg::*;

    localparam int unsigned TMO = 300;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    wr_sel;
    logic [18:0]   wr_addr;
    logic [3:0]    wr_data;
    logic          busy;
    logic          done;
    logic [3:0]    err;
    loader_state_t state_dbg;

    always #5 Clk = ~Clk;

    sprite_ram_writer #(.TIMEOUT(TMO)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_viol = 0;
    int acc_cyc  = 0;
    int gap_max  = 2;

    logic [25:0] exp_q[$];      // {sel, addr, data}
    logic [25:0] act_w[$];
    int          act_wc[$];
    logic [4:0]  exp_ev[$];     // {err[3:0], done}
    logic [4:0]  act_ev[$];
    int          act_evc[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  pl_q[$];

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (!Reset) begin
            if (wr_sel != 3'b000) begin
                act_w.push_back({wr_sel, wr_addr, wr_data});
                act_wc.push_back(cyc);
                if (in_ready) rdy_viol++;
            end
            if (done || err != 4'b0000) begin
                act_ev.push_back({err, done});
                act_evc.push_back(cyc);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        exp_q.delete(); act_w.delete(); act_wc.delete();
        exp_ev.delete(); act_ev.delete(); act_evc.delete();
        tx_q.delete(); pl_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge Clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge Clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge Clk);
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_wait byte=%h in_ready=%b after %0d cycles, required 1", b, in_ready, waited);
        end
        @(posedge Clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_frame();
        foreach (tx_q[i]) send_byte(tx_q[i], $urandom_range(0, gap_max));
    endtask

    // Reference model: appends one frame to tx_q and its expected writes and pulse.
    // chk_mode: -1 correct checksum, -2 corrupted checksum, >=0 explicit byte.
    task automatic build_frame(input int tgt, input int len, input int ofs,
                               input int chk_mode, input int junk);
        int cap, base, nb;
        logic [7:0] x, c, c_sent;
        logic [2:0] sel;
        repeat (junk) begin
            x = 8'($urandom);
            if (x == 8'hA5) x = 8'h00;
            tx_q.push_back(x);
        end
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'(tgt));
        if (tgt > 2) begin
            exp_ev.push_back(5'b00010);
            pl_q.delete();
            return;
        end
        tx_q.push_back(8'(len % 256));
        tx_q.push_back(8'(len / 256));
        cap  = (tgt == 0) ? 1600 : (tgt == 1) ? 38400 : 307200;
        base = (tgt == 2) ? ofs * 65536 : 0;
        if (tgt == 2) tx_q.push_back(8'(ofs));
        if (base + len > cap) begin
            exp_ev.push_back(5'b00100);
            pl_q.delete();
            return;
        end
        nb = (len + 1) / 2;
        while (pl_q.size() < nb) pl_q.push_back(8'($urandom));
        sel = 3'(1 << tgt);
        c = 8'h00;
        for (int i = 0; i < nb; i++) begin
            tx_q.push_back(pl_q[i]);
            c = c ^ pl_q[i];
        end
        for (int p = 0; p < len; p++) begin
            x = pl_q[p / 2];
            exp_q.push_back({sel, 19'(base + p), (p % 2 == 1) ? x[7:4] : x[3:0]});
        end
        if (chk_mode == -2)      c_sent = c ^ 8'($urandom_range(1, 255));
        else if (chk_mode == -1) c_sent = c;
        else                     c_sent = 8'(chk_mode);
        tx_q.push_back(c_sent);
        exp_ev.push_back((c_sent == c) ? 5'b00001 : 5'b01000);
        pl_q.delete();
    endtask

    task automatic test_reset();
        Reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge Clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge Clk); #1;
        total++; if (wr_sel !== 3'b000) begin bad++; $display("FAIL reset_wr_sel got=%b exp=000", wr_sel); end
        total++; if (wr_addr !== 19'd0) begin bad++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        total++; if (wr_data !== 4'h0) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (err !== 4'b0000) begin bad++; $display("FAIL reset_err got=%b exp=0000", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        Reset    = 1'b0;
        @(posedge Clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_directed();
        string tag;
        for (int k = 0; k < 10; k++) begin
            clear_obs();
            case (k)
                0: begin tag = "bird";       pl_q.push_back(8'h21); pl_q.push_back(8'h43); build_frame(0, 4, 0, 'h62, 0); end
                1: begin tag = "pipe_odd";   pl_q.push_back(8'h65); pl_q.push_back(8'h07); build_frame(1, 3, 0, 'h62, 0); end
                2: begin tag = "bad_chk";    pl_q.push_back(8'h21); pl_q.push_back(8'h43); build_frame(0, 4, 0, 'h00, 0); end
                3: begin tag = "bad_tgt";    build_frame(3, 0, 0, -1, 0); end
                4: begin tag = "bird_over";  build_frame(0, 1601, 0, -1, 0); end
                5: begin tag = "after_err";  pl_q.push_back(8'h21); pl_q.push_back(8'h43); build_frame(0, 4, 0, -1, 3); end
                6: begin tag = "back_ofs";   pl_q.push_back(8'hBA); build_frame(2, 2, 4, 'hBA, 0); end
                7: begin tag = "back_over";  build_frame(2, 45057, 4, -1, 0); end
                8: begin tag = "zero_len";   build_frame(1, 0, 0, -1, 0); end
                default: begin tag = "bird_full"; build_frame(0, 1600, 0, -1, 0); end
            endcase
            send_frame();
            repeat (6) @(posedge Clk); #1;
            total++;
            if (act_w.size() != exp_q.size()) begin
                bad++; $display("FAIL %s write_count got=%0d exp=%0d", tag, act_w.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < act_w.size(); i++) begin
                total++;
                if (act_w[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s write[%0d] got sel=%b addr=%0d data=%h exp sel=%b addr=%0d data=%h", tag, i,
                             act_w[i][25:23], act_w[i][22:4], act_w[i][3:0], exp_q[i][25:23], exp_q[i][22:4], exp_q[i][3:0]);
                end
            end
            total++;
            if (act_ev.size() != exp_ev.size()) begin
                bad++; $display("FAIL %s pulse_count got=%0d exp=%0d", tag, act_ev.size(), exp_ev.size());
            end
            for (int i = 0; i < exp_ev.size() && i < act_ev.size(); i++) begin
                total++;
                if (act_ev[i] !== exp_ev[i]) begin
                    bad++; $display("FAIL %s pulse[%0d] got {err,done}=%b exp=%b", tag, i, act_ev[i], exp_ev[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_obs();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'h21, 0);
        total++; if ({wr_sel, wr_addr, wr_data} !== {3'b001, 19'd0, 4'h1}) begin
            bad++; $display("FAIL mid_wlo got sel=%b addr=%0d data=%h exp sel=001 addr=0 data=1", wr_sel, wr_addr, wr_data);
        end
        @(posedge Clk); #1;
        total++; if ({wr_sel, wr_addr, wr_data} !== {3'b001, 19'd1, 4'h2}) begin
            bad++; $display("FAIL mid_whi got sel=%b addr=%0d data=%h exp sel=001 addr=1 data=2", wr_sel, wr_addr, wr_data);
        end
        Reset = 1'b1;
        @(posedge Clk); #1;
        total++; if (wr_sel !== 3'b000) begin bad++; $display("FAIL mid_reset_wr_sel got=%b exp=000", wr_sel); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
        total++; if ({err, done} !== 5'b00000) begin bad++; $display("FAIL mid_reset_pulses got=%b exp=00000", {err, done}); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_in_ready got=%b exp=0", in_ready); end
        Reset = 1'b0;
        repeat (4) @(posedge Clk); #1;
        total++; if (act_ev.size() != 0) begin bad++; $display("FAIL mid_reset_no_pulse got=%0d exp=0", act_ev.size()); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_timeout();
        int w = 0;
        int d;
        clear_obs();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        while (act_ev.size() == 0 && w < int'(TMO) + 20) begin
            @(posedge Clk); w++;
        end
        @(posedge Clk); #1;
        total++;
        if (act_ev.size() != 1) begin
            bad++; $display("FAIL timeout_pulse_count got=%0d exp=1", act_ev.size());
        end else begin
            total++;
            if (act_ev[0] !== 5'b10000) begin bad++; $display("FAIL timeout_pulse got=%b exp=10000", act_ev[0]); end
            d = act_evc[0] - acc_cyc;
            total++;
            if (d < int'(TMO) - 1 || d > int'(TMO) + 1) begin
                bad++; $display("FAIL timeout_latency got=%0d exp=%0d+-1", d, TMO);
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b exp=0", busy); end
        total++; if (act_w.size() != 0) begin bad++; $display("FAIL timeout_writes got=%0d exp=0", act_w.size()); end
        act_ev.delete();
        repeat (2 * TMO) @(posedge Clk); #1;
        total++; if (act_ev.size() != 0) begin bad++; $display("FAIL idle_no_timeout got=%0d exp=0", act_ev.size()); end
    endtask

    task automatic test_random();
        int tgt, len, ofs, chk_mode;
        for (int f = 0; f < 14; f++) begin
            clear_obs();
            tgt = ($urandom_range(0, 9) == 9) ? 3 : $urandom_range(0, 2);
            len = $urandom_range(0, 40);
            if (tgt == 0 && $urandom_range(0, 3) == 0) len = $urandom_range(1595, 1605);
            ofs = $urandom_range(0, 5);
            chk_mode = ($urandom_range(0, 3) == 0) ? -2 : -1;
            build_frame(tgt, len, ofs, chk_mode, $urandom_range(0, 2));
            send_frame();
            repeat (6) @(posedge Clk); #1;
            total++;
            if (act_w.size() != exp_q.size()) begin
                bad++; $display("FAIL rnd%0d write_count got=%0d exp=%0d (tgt=%0d len=%0d ofs=%0d)", f, act_w.size(), exp_q.size(), tgt, len, ofs);
            end
            for (int i = 0; i < exp_q.size() && i < act_w.size(); i++) begin
                total++;
                if (act_w[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rnd%0d write[%0d] got=%h exp=%h", f, i, act_w[i], exp_q[i]);
                end
            end
            total++;
            if (act_ev.size() != exp_ev.size() || (exp_ev.size() > 0 && act_ev[0] !== exp_ev[0])) begin
                bad++; $display("FAIL rnd%0d pulse got n=%0d first=%b exp n=%0d first=%b", f, act_ev.size(),
                                (act_ev.size() > 0) ? act_ev[0] : 5'b0, exp_ev.size(), (exp_ev.size() > 0) ? exp_ev[0] : 5'b0);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        gap_max  = 0;
        rdy_viol = 0;
        for (int f = 0; f < 4; f++) build_frame($urandom_range(0, 2), $urandom_range(5, 20), $urandom_range(0, 4), -1, 0);
        send_frame();
        repeat (6) @(posedge Clk); #1;
        gap_max = 2;
        total++;
        if (act_w.size() != exp_q.size()) begin
            bad++; $display("FAIL b2b write_count got=%0d exp=%0d", act_w.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_w.size(); i++) begin
            total++;
            if (act_w[i] !== exp_q[i]) begin
                bad++; $display("FAIL b2b write[%0d] got=%h exp=%h", i, act_w[i], exp_q[i]);
            end
            // High nibble follows its low nibble on the very next cycle.
            if (i > 0 && exp_q[i][4] == 1'b1) begin
                total++;
                if (act_wc[i] - act_wc[i-1] != 1) begin
                    bad++; $display("FAIL b2b pair_gap[%0d] got=%0d exp=1", i, act_wc[i] - act_wc[i-1]);
                end
            end
        end
        total++;
        if (act_ev.size() != 4) begin
            bad++; $display("FAIL b2b done_count got=%0d exp=4", act_ev.size());
        end
        for (int i = 0; i < act_ev.size() && i < 4; i++) begin
            total++;
            if (act_ev[i] !== 5'b00001) begin bad++; $display("FAIL b2b pulse[%0d] got=%b exp=00001", i, act_ev[i]); end
        end
        total++; if (rdy_viol != 0) begin bad++; $display("FAIL b2b ready_during_write got=%0d exp=0", rdy_viol); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_midframe();
        test_timeout();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
